// File: rtl/mainfsm_pkg.sv
// Shared encodings for the multicycle ARM main controller: state codes,
// instruction Op fields, datapath select values and the control word layout.
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd15
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

  localparam logic [1:0] SRCA_REG = 2'b00;
  localparam logic [1:0] SRCA_PC  = 2'b01;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef struct packed {
    logic       irWrite;
    logic       adrSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] resultSrc;
    logic       nextPc;
    logic       regW;
    logic       memW;
    logic       branch;
    logic       aluOp;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// Moore output decode: maps the current state onto the datapath control word.
// Any state without an entry (UNKNOWN and unused codes) yields an all-zero word.
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_e i_state,
  output ctrl_t  o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.irWrite   = 1'b1;
        o_ctrl.aluSrcA   = SRCA_PC;
        o_ctrl.aluSrcB   = SRCB_FOUR;
        o_ctrl.resultSrc = RES_ALU;
        o_ctrl.nextPc    = 1'b1;
      end
      S_DECODE: begin
        o_ctrl.aluSrcA   = SRCA_PC;
        o_ctrl.aluSrcB   = SRCB_FOUR;
        o_ctrl.resultSrc = RES_ALU;
      end
      S_MEMADR: begin
        o_ctrl.aluSrcA   = SRCA_REG;
        o_ctrl.aluSrcB   = SRCB_IMM;
      end
      S_MEMRD: begin
        o_ctrl.adrSrc    = 1'b1;
        o_ctrl.resultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        o_ctrl.resultSrc = RES_DATA;
        o_ctrl.regW      = 1'b1;
      end
      S_MEMWR: begin
        o_ctrl.adrSrc    = 1'b1;
        o_ctrl.resultSrc = RES_ALUOUT;
        o_ctrl.memW      = 1'b1;
      end
      S_EXECUTER: begin
        o_ctrl.aluSrcA   = SRCA_REG;
        o_ctrl.aluSrcB   = SRCB_REG;
        o_ctrl.aluOp     = 1'b1;
      end
      S_EXECUTEI: begin
        o_ctrl.aluSrcA   = SRCA_REG;
        o_ctrl.aluSrcB   = SRCB_IMM;
        o_ctrl.aluOp     = 1'b1;
      end
      S_ALUWB: begin
        o_ctrl.resultSrc = RES_ALUOUT;
        o_ctrl.regW      = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.aluSrcA   = SRCA_REG;
        o_ctrl.aluSrcB   = SRCB_IMM;
        o_ctrl.resultSrc = RES_ALU;
        o_ctrl.branch    = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// Main control FSM of the multicycle ARM datapath: state register, next-state
// logic from the latched Op/Funct fields, and the raw write-enable requests.
module mainfsm
  import mainfsm_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               ALUOp,
  output logic [STATE_W-1:0] State
);

  state_e r_state;
  state_e w_nextState;
  logic   r_run;
  ctrl_t  w_ctrl;
  logic   w_unusedFunct;

  // r_run holds FETCH for the first edge after reset release, so the FETCH
  // enables are seen for one full cycle before DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
    end else begin
      r_run   <= 1'b1;
      r_state <= r_run ? w_nextState : S_FETCH;
    end
  end

  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  w_nextState = S_MEMADR;
          OP_DP:   w_nextState = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_B:    w_nextState = S_BRANCH;
          default: w_nextState = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   w_nextState = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_nextState = S_MEMWB;
      S_EXECUTER: w_nextState = S_ALUWB;
      S_EXECUTEI: w_nextState = S_ALUWB;
      default:    w_nextState = S_FETCH;
    endcase
  end

  assign w_unusedFunct = ^Funct[4:1];

  mainfsm_outdec u_outdec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // Enables are gated off while in reset and until the first post-reset edge.
  assign IRWrite   = w_ctrl.irWrite & r_run;
  assign NextPC    = w_ctrl.nextPc  & r_run;
  assign RegW      = w_ctrl.regW    & r_run;
  assign MemW      = w_ctrl.memW    & r_run;
  assign Branch    = w_ctrl.branch  & r_run;
  assign AdrSrc    = w_ctrl.adrSrc;
  assign ALUSrcA   = w_ctrl.aluSrcA;
  assign ALUSrcB   = w_ctrl.aluSrcB;
  assign ResultSrc = w_ctrl.resultSrc;
  assign ALUOp     = w_ctrl.aluOp;
  assign State     = STATE_W'(r_state);

endmodule

// File: tb/tb_mainfsm.sv
// Directed self-checking bench for mainfsm: walks every instruction class and
// an asynchronous mid-instruction reset, comparing state and control word.
module tb_mainfsm;

  logic       clk;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;
  logic [12:0] obsWord;

  int testsRun = 0;
  int testsFailed = 0;

  // Word layout: IRWrite AdrSrc ALUSrcA ALUSrcB ResultSrc NextPC RegW MemW Branch ALUOp
  localparam logic [12:0] W_RESET  = 13'b0_0_01_10_10_0_0_0_0_0;
  localparam logic [12:0] W_FETCH  = 13'b1_0_01_10_10_1_0_0_0_0;
  localparam logic [12:0] W_DECODE = 13'b0_0_01_10_10_0_0_0_0_0;
  localparam logic [12:0] W_MEMADR = 13'b0_0_00_01_00_0_0_0_0_0;
  localparam logic [12:0] W_MEMRD  = 13'b0_1_00_00_00_0_0_0_0_0;
  localparam logic [12:0] W_MEMWB  = 13'b0_0_00_00_01_0_1_0_0_0;
  localparam logic [12:0] W_MEMWR  = 13'b0_1_00_00_00_0_0_1_0_0;
  localparam logic [12:0] W_EXER   = 13'b0_0_00_00_00_0_0_0_0_1;
  localparam logic [12:0] W_EXEI   = 13'b0_0_00_01_00_0_0_0_0_1;
  localparam logic [12:0] W_ALUWB  = 13'b0_0_00_00_00_0_1_0_0_0;
  localparam logic [12:0] W_BRANCH = 13'b0_0_00_01_10_0_0_0_1_0;
  localparam logic [12:0] W_ZERO   = 13'b0_0_00_00_00_0_0_0_0_0;

  mainfsm #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .State     (State)
  );

  assign obsWord = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                    NextPC, RegW, MemW, Branch, ALUOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] op, input logic [5:0] funct);
    Op    = op;
    Funct = funct;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expState,
                             input logic [12:0] expWord);
    testsRun++;
    assert (State === expState) else begin
      testsFailed++;
      $error("[TB] FAIL %s state: observed %0d expected %0d", tag, State, expState);
    end
    testsRun++;
    assert (obsWord === expWord) else begin
      testsFailed++;
      $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, obsWord, expWord);
    end
  endtask

  task automatic stepCheck(input string tag, input logic [3:0] expState,
                           input logic [12:0] expWord);
    @(negedge clk);
    checkOutput(tag, expState, expWord);
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(2'b00, 6'b000000);
    repeat (3) @(negedge clk);
    checkOutput("reset_hold", 4'd0, W_RESET);
    reset = 1'b1;
    #1 checkOutput("reset_released_pre_edge", 4'd0, W_RESET);
    stepCheck("first_fetch", 4'd0, W_FETCH);

    applyStimulus(2'b01, 6'b000001);
    stepCheck("ldr_decode", 4'd1, W_DECODE);
    stepCheck("ldr_memadr", 4'd2, W_MEMADR);
    stepCheck("ldr_memrd", 4'd3, W_MEMRD);
    applyStimulus(2'b11, 6'b000000);
    stepCheck("ldr_memwb", 4'd4, W_MEMWB);
    stepCheck("ldr_fetch", 4'd0, W_FETCH);

    applyStimulus(2'b01, 6'b000000);
    stepCheck("str_decode", 4'd1, W_DECODE);
    stepCheck("str_memadr", 4'd2, W_MEMADR);
    stepCheck("str_memwr", 4'd5, W_MEMWR);
    stepCheck("str_fetch", 4'd0, W_FETCH);

    applyStimulus(2'b00, 6'b101000);
    stepCheck("dpi_decode", 4'd1, W_DECODE);
    stepCheck("dpi_executei", 4'd7, W_EXEI);
    applyStimulus(2'b10, 6'b000000);
    stepCheck("dpi_aluwb", 4'd8, W_ALUWB);
    stepCheck("dpi_fetch", 4'd0, W_FETCH);

    applyStimulus(2'b00, 6'b001000);
    stepCheck("dpr_decode", 4'd1, W_DECODE);
    stepCheck("dpr_executer", 4'd6, W_EXER);
    stepCheck("dpr_aluwb", 4'd8, W_ALUWB);
    stepCheck("dpr_fetch", 4'd0, W_FETCH);

    applyStimulus(2'b10, 6'b100000);
    stepCheck("b_decode", 4'd1, W_DECODE);
    stepCheck("b_branch", 4'd9, W_BRANCH);
    stepCheck("b_fetch", 4'd0, W_FETCH);

    applyStimulus(2'b11, 6'b111111);
    stepCheck("undef_decode", 4'd1, W_DECODE);
    stepCheck("undef_unknown", 4'd15, W_ZERO);
    stepCheck("undef_fetch", 4'd0, W_FETCH);

    applyStimulus(2'b01, 6'b000000);
    stepCheck("rst_str_decode", 4'd1, W_DECODE);
    stepCheck("rst_str_memadr", 4'd2, W_MEMADR);
    stepCheck("rst_str_memwr", 4'd5, W_MEMWR);
    #2 reset = 1'b0;
    #1 checkOutput("async_reset_memwr", 4'd0, W_RESET);
    #1 reset = 1'b1;
    stepCheck("restart_fetch", 4'd0, W_FETCH);
    stepCheck("restart_decode", 4'd1, W_DECODE);
    stepCheck("restart_memadr", 4'd2, W_MEMADR);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
